sram_like_arbiter: RTL and testbench

SRAM_LIKE_ARBITER -- requirements
Module: sram_like_arbiter

---
 rtl/sram_like_arbiter.sv | 141 ++++++++++++++
 tb/tb_sram_like_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// Two-master (inst/data) to one-slave sram-like bus arbiter.
// Keeps at most one bus transaction outstanding. Data normally wins, but inst is
// guaranteed a grant after STARVE_MAX back-to-back data grants made while it waited.
module sram_like_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rstn,
   // inst master port
   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [31:0] inst_addr,
   output logic [31:0] inst_rdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   // data master port
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   // shared slave port
   output logic        bus_req,
   output logic        bus_wr,
   output logic [1:0]  bus_size,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_addr_ok,
   input  logic        bus_data_ok,
   // status
   output logic        busy,
   output logic        grant_data
);

   localparam int unsigned CntWRaw = $clog2(STARVE_MAX + 1);
   localparam int unsigned CntW    = (CntWRaw > 3) ? CntWRaw : 3;
   localparam logic [CntW-1:0] StarveMax = CntW'(STARVE_MAX);

   typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

   state_e          state_q, state_d;
   logic            grant_data_q, grant_data_d;
   logic [CntW-1:0] starve_cnt_q, starve_cnt_d;
   logic [31:0]     inst_rdata_q, inst_rdata_d;
   logic [31:0]     data_rdata_q, data_rdata_d;

   logic            sel_data;
   logic            addr_ok_pulse;
   logic            data_ok_pulse;

   // Arbitration, starvation counter and state transitions
   always_comb begin
      state_d      = state_q;
      grant_data_d = grant_data_q;
      starve_cnt_d = starve_cnt_q;
      // inst only overrides data once it has been passed over StarveMax times
      sel_data     = data_req && !(inst_req && (starve_cnt_q == StarveMax));
      unique case (state_q)
         StIdle: begin
            if (inst_req || data_req) begin
               state_d      = StAddr;
               grant_data_d = sel_data;
               if (sel_data && inst_req) begin
                  if (starve_cnt_q < StarveMax) starve_cnt_d = starve_cnt_q + CntW'(1);
               end else begin
                  starve_cnt_d = '0;
               end
            end
         end
         StAddr: begin
            if (bus_addr_ok) state_d = bus_data_ok ? StIdle : StData;
         end
         StData: begin
            if (bus_data_ok) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Handshake pulses, bus pass-through and read-data hold
   always_comb begin
      // Pulses are masked during reset so an abandoned transaction never completes
      addr_ok_pulse = rstn && (state_q == StAddr) && bus_addr_ok;
      data_ok_pulse = rstn && bus_data_ok &&
                      (((state_q == StAddr) && bus_addr_ok) || (state_q == StData));

      inst_addr_ok = addr_ok_pulse && !grant_data_q;
      inst_data_ok = data_ok_pulse && !grant_data_q;
      data_addr_ok = addr_ok_pulse &&  grant_data_q;
      data_data_ok = data_ok_pulse &&  grant_data_q;

      bus_req   = (state_q == StAddr);
      bus_wr    = 1'b0;
      bus_size  = 2'b00;
      bus_addr  = 32'h0;
      bus_wdata = 32'h0;
      if (state_q == StAddr) begin
         if (grant_data_q) begin
            bus_wr    = data_wr;
            bus_size  = data_size;
            bus_addr  = data_addr;
            bus_wdata = data_wdata;
         end else begin
            bus_wr    = inst_wr;
            bus_size  = inst_size;
            bus_addr  = inst_addr;
         end
      end

      inst_rdata   = inst_data_ok ? bus_rdata : inst_rdata_q;
      data_rdata   = data_data_ok ? bus_rdata : data_rdata_q;
      inst_rdata_d = inst_rdata;
      data_rdata_d = data_rdata;

      busy       = (state_q != StIdle);
      grant_data = grant_data_q;
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= StIdle;
         grant_data_q <= 1'b0;
         starve_cnt_q <= '0;
         inst_rdata_q <= 32'h0;
         data_rdata_q <= 32'h0;
      end else begin
         state_q      <= state_d;
         grant_data_q <= grant_data_d;
         starve_cnt_q <= starve_cnt_d;
         inst_rdata_q <= inst_rdata_d;
         data_rdata_q <= data_rdata_d;
      end
   end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed, table-driven bench for sram_like_arbiter.
module tb_sram_like_arbiter;

   localparam logic [31:0] IA = 32'hBFC0_0000;
   localparam logic [31:0] DA = 32'h8000_1000;
   localparam logic [31:0] DW = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        rstn;
   logic        inst_req, inst_wr;
   logic [1:0]  inst_size;
   logic [31:0] inst_addr, inst_rdata;
   logic        inst_addr_ok, inst_data_ok;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic        data_addr_ok, data_data_ok;
   logic        bus_req, bus_wr;
   logic [1:0]  bus_size;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic        bus_addr_ok, bus_data_ok;
   logic        busy, grant_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sram_like_arbiter #(.STARVE_MAX(4)) dut (
      .clk(clk), .rstn(rstn),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
      .inst_rdata(inst_rdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_rdata(data_rdata), .data_addr_ok(data_addr_ok),
      .data_data_ok(data_data_ok),
      .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_addr_ok(bus_addr_ok),
      .bus_data_ok(bus_data_ok),
      .busy(busy), .grant_data(grant_data)
   );

   typedef struct {
      logic        rstn, ireq, dreq, dwr, aok, dok;
      logic [31:0] rdata;
      logic        breq, gd, bsy, iaok, idok, daok, ddok;
      logic [31:0] irdata, drdata;
   } vec_t;

   function automatic vec_t mk(input logic r, ir, dr, dw, ao, dk, input logic [31:0] rd,
                               input logic br, g, b, ia, id, da, dd,
                               input logic [31:0] ird, drd);
      vec_t v;
      v.rstn = r; v.ireq = ir; v.dreq = dr; v.dwr = dw; v.aok = ao; v.dok = dk; v.rdata = rd;
      v.breq = br; v.gd = g; v.bsy = b; v.iaok = ia; v.idok = id; v.daok = da; v.ddok = dd;
      v.irdata = ird; v.drdata = drd;
      return v;
   endfunction

   localparam int NVec = 21;
   vec_t vecs[NVec];

   logic [70:0] act_o, exp_o;
   logic [66:0] act_b, exp_b;
   logic [9:0]  order;
   int          ngrant;

   initial begin
      //               rst ir dr dw ao dk rdata         br gd by ia id da dd irdata        drdata
      vecs[0]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0);
      // single inst read
      vecs[1]  = mk(1, 1, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0);
      vecs[2]  = mk(1, 1, 0, 0, 1, 0, 32'h0,        1, 0, 1, 1, 0, 0, 0, 32'h0,        32'h0);
      vecs[3]  = mk(1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 1, 0, 0, 0, 0, 32'h0,        32'h0);
      vecs[4]  = mk(1, 0, 0, 0, 0, 1, 32'h3C010001, 0, 0, 1, 0, 1, 0, 0, 32'h3C010001, 32'h0);
      vecs[5]  = mk(1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 32'h3C010001, 32'h0);
      // stray data_ok in idle
      vecs[6]  = mk(1, 0, 0, 0, 0, 1, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 32'h3C010001, 32'h0);
      // simultaneous requests: data write wins, stray addr_ok in DATA
      vecs[7]  = mk(1, 1, 1, 1, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 32'h3C010001, 32'h0);
      vecs[8]  = mk(1, 1, 1, 1, 1, 0, 32'h0,        1, 1, 1, 0, 0, 1, 0, 32'h3C010001, 32'h0);
      vecs[9]  = mk(1, 1, 0, 0, 1, 0, 32'h0,        0, 1, 1, 0, 0, 0, 0, 32'h3C010001, 32'h0);
      vecs[10] = mk(1, 1, 0, 0, 0, 1, 32'h11112222, 0, 1, 1, 0, 0, 0, 1, 32'h3C010001, 32'h11112222);
      vecs[11] = mk(1, 1, 0, 0, 0, 0, 32'h0,        0, 1, 0, 0, 0, 0, 0, 32'h3C010001, 32'h11112222);
      // inst served next, same-cycle addr_ok + data_ok
      vecs[12] = mk(1, 1, 0, 0, 1, 1, 32'h55556666, 1, 0, 1, 1, 1, 0, 0, 32'h55556666, 32'h11112222);
      vecs[13] = mk(1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 32'h55556666, 32'h11112222);
      // data read, then reset in DATA, then late data_ok
      vecs[14] = mk(1, 0, 1, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 32'h55556666, 32'h11112222);
      vecs[15] = mk(1, 0, 1, 0, 1, 0, 32'h0,        1, 1, 1, 0, 0, 1, 0, 32'h55556666, 32'h11112222);
      vecs[16] = mk(1, 0, 0, 0, 0, 0, 32'h0,        0, 1, 1, 0, 0, 0, 0, 32'h55556666, 32'h11112222);
      vecs[17] = mk(0, 0, 0, 0, 0, 0, 32'h0,        0, 1, 1, 0, 0, 0, 0, 32'h55556666, 32'h11112222);
      vecs[18] = mk(1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0);
      vecs[19] = mk(1, 0, 0, 0, 0, 1, 32'h99999999, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0);
      vecs[20] = mk(1, 0, 0, 0, 0, 0, 32'h0,        0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0);

      inst_wr = 1'b0; inst_size = 2'd2; inst_addr = IA;
      data_size = 2'd1; data_addr = DA; data_wdata = DW;
      rstn = 1'b0; inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0;
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'h0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < NVec; i++) begin
         @(posedge clk);
         #1;
         rstn        = vecs[i].rstn;
         inst_req    = vecs[i].ireq;
         data_req    = vecs[i].dreq;
         data_wr     = vecs[i].dwr;
         bus_addr_ok = vecs[i].aok;
         bus_data_ok = vecs[i].dok;
         bus_rdata   = vecs[i].rdata;
         @(negedge clk);
         act_o = {bus_req, grant_data, busy, inst_addr_ok, inst_data_ok, data_addr_ok,
                  data_data_ok, inst_rdata, data_rdata};
         exp_o = {vecs[i].breq, vecs[i].gd, vecs[i].bsy, vecs[i].iaok, vecs[i].idok,
                  vecs[i].daok, vecs[i].ddok, vecs[i].irdata, vecs[i].drdata};
         checks++;
         if (act_o !== exp_o) begin
            errors++;
            $display("FAIL vec%0d outputs: got %h expected %h", i, act_o, exp_o);
         end
         if (vecs[i].breq) begin
            act_b = {bus_addr, bus_wr, bus_size, bus_wdata};
            exp_b = vecs[i].gd ? {DA, vecs[i].dwr, 2'd1, DW} : {IA, 1'b0, 2'd2, 32'h0};
            checks++;
            if (act_b !== exp_b) begin
               errors++;
               $display("FAIL vec%0d bus_fields: got %h expected %h", i, act_b, exp_b);
            end
         end
      end

      // Starvation: both masters request continuously, slave completes in ADDR
      @(posedge clk);
      #1;
      rstn = 1'b0; inst_req = 1'b0; data_req = 1'b0; bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rstn = 1'b1; inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b0;
      bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h0;
      order  = 10'b01_1110_1111; // bit n = 1 means grant n goes to data
      ngrant = 0;
      for (int c = 0; c < 40 && ngrant < 10; c++) begin
         @(negedge clk);
         if (busy) begin
            checks++;
            if (grant_data !== order[ngrant]) begin
               errors++;
               $display("FAIL starve_grant%0d: got grant_data=%b expected %b",
                        ngrant, grant_data, order[ngrant]);
            end
            ngrant++;
         end
      end
      checks++;
      if (ngrant != 10) begin
         errors++;
         $display("FAIL starve_count: got %0d grants expected 10", ngrant);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
